pl_reg_skid: RTL and testbench
==============================

// Module: pl_reg_skid
// PURPOSE
//  Parametrised pipeline-stage register with valid/ready handshake and a 2-entry
//  skid buffer. Generalised successor of the fixed inter-stage registers: one
//  WIDTH-bit payload bus carries any stage bundle (e.g. MW: 4x32 + 2 + 1 = 131).
//  Backpressure is absorbed without a combinational ready path across stages.
//  Adds synchronous flush and a saturating stall counter for performance monitoring.
// PARAMETERS
//  WIDTH     131  payload width in bits (>=1)
//  CNT_W     16   stall counter width (>=1)
//  CLR_DATA  1    1: flush also zeroes payload registers; 0: flush clears valid state only
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-high
//  clr        in   1      synchronous flush (squash), active-high
//  in_valid   in   1      upstream payload valid
//  in_ready   out  1      stage accepts payload this cycle (registered)
//  in_data    in   WIDTH  upstream payload
//  out_valid  out  1      downstream payload valid
//  out_ready  in   1      downstream accepts payload
//  out_data   out  WIDTH  payload to downstream (registered)
//  occupancy  out  2      entries held: 0, 1 or 2
//  stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
// BEHAVIOUR
//  - Reset (async, rst=1): state=EMPTY, main/skid regs=0, stall_cnt=0 -> out_valid=0,
//    in_ready=1, out_data=0, occupancy=0. Reset mid-transfer discards both entries.
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Registers: main (drives out_data), skid (overflow). State: EMPTY, ONE, FULL.
//  - out_valid = (state!=EMPTY); in_ready = (state!=FULL); occupancy = 0/1/2 per state.
//    All three decode state only; no comb path from out_ready or in_valid.
//  - Transitions (when clr=0):
//    EMPTY: in_fire -> main<=in_data, ONE.
//    ONE:   in_fire&out_fire -> main<=in_data, ONE;  in_fire only -> skid<=in_data, FULL;
//           out_fire only -> EMPTY;  neither -> hold.
//    FULL:  out_fire -> main<=skid, ONE;  else hold. in_valid ignored (in_ready=0).
//  - Latency: payload accepted at edge N is on out_data after edge N (1 cycle) when
//    the stage was EMPTY or draining; ordering strictly FIFO, no drops, no duplicates.
//  - Throughput: 1 transfer/cycle sustained with out_ready=1.
//  - clr (sync): highest priority over all transfers that cycle; next state EMPTY;
//    in-flight in_data is dropped; if CLR_DATA=1, main and skid <= 0. clr with rst=1:
//    rst wins. clr does not affect stall_cnt.
//  - stall_cnt: +1 on each edge where out_valid & !out_ready; holds at 2^CNT_W-1;
//    cleared only by rst.
//  - Payload registers load only on the transitions above (no enable toggling when
//    idle).
// STRUCTURE
//  - pl_pkg: localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2; bundle widths
//    FD_W, DE_W, EM_W, MW_W=131 for instantiating each pipeline stage.
//  - One sub-module: pl_sat_cnt #(CNT_W) (inc, clr-by-rst, saturate) for stall_cnt.
//  - State register, main/skid registers and output decode in this module.
// TESTING
//  1 Reset: assert rst mid-stream with FULL -> same cycle out_valid=0, in_ready=1,
//    occupancy=0, out_data=0, stall_cnt=0.
//  2 Streaming: out_ready=1, send 0x1..0x8 back-to-back -> out_data 0x1..0x8 one cycle
//    later, in order, in_ready=1 throughout.
//  3 Backpressure: send 0xA,0xB,0xC with out_ready=0 -> occupancy 1 then 2, in_ready=0
//    after 0xB, 0xC held upstream; raise out_ready -> 0xA,0xB,0xC delivered in order.
//  4 Flush: FULL with 0xA/0xB, pulse clr with in_valid=1 (0xC) -> next cycle EMPTY,
//    out_valid=0; CLR_DATA=1 -> out_data=0; 0xC never emerges.
//  5 Counter: CNT_W=3, out_valid=1, out_ready=0 for 10 cycles -> stall_cnt reaches 7
//    and holds; clr leaves it at 7; rst -> 0.
//  6 Random: random in_valid/out_ready/clr, 10k cycles -> scoreboard FIFO order,
//    occupancy<=2.

Source files
------------

// File: rtl/pl_pkg.sv
// ----------------------------------------------------------------------------
// pl_pkg
// Shared definitions for the pipeline-stage register (pl_reg_skid) and the
// stage payload bundle widths used when instantiating one register per
// pipeline boundary.
//
// Contents:
//   ST_EMPTY/ST_ONE/ST_FULL : state encodings (value equals entries held)
//   state_t                 : enumerated state type built on those encodings
//   FD_W, DE_W, EM_W, MW_W  : payload widths of the inter-stage bundles
// ----------------------------------------------------------------------------
package pl_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_FULL  = ST_FULL
    } state_t;

    // Fetch->decode: pc + instruction word.
    localparam int FD_W = 32 + 32;
    // Decode->execute: pc + two operands + immediate + rd index + control.
    localparam int DE_W = 32 + 32 + 32 + 32 + 5 + 8;
    // Execute->memory: result + store data + rd index + control.
    localparam int EM_W = 32 + 32 + 5 + 4;
    // Memory->writeback: 4x32 data words + 2-bit selector + write enable.
    localparam int MW_W = 4 * 32 + 2 + 1;

endpackage : pl_pkg

// File: rtl/pl_sat_cnt.sv
// ----------------------------------------------------------------------------
// pl_sat_cnt
// Saturating event counter. Increments by one on every rising clock edge
// where inc is high and sticks at its all-ones value. Only the asynchronous
// reset clears it.
//
// Ports:
//   clk  in   1      rising-edge clock
//   rst  in   1      asynchronous reset, active-high (count -> 0)
//   inc  in   1      count this cycle
//   cnt  out  CNT_W  current count
// ----------------------------------------------------------------------------
module pl_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // One-step saturating increment.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule : pl_sat_cnt

// File: rtl/pl_reg_skid.sv
// ----------------------------------------------------------------------------
// pl_reg_skid
// Pipeline-stage register with valid/ready handshake and a 2-entry skid
// buffer. The "main" register always drives out_data; the "skid" register
// catches the one extra payload that can arrive in the cycle downstream
// stalls, so in_ready can be produced from a flop instead of from out_ready.
// A synchronous flush squashes both entries; a saturating counter records
// cycles where the stage holds data that downstream refuses.
//
// Parameters:
//   WIDTH     payload width in bits
//   CNT_W     stall counter width
//   CLR_DATA  1: flush also zeroes the payload registers
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-high
//   clr        in   1      synchronous flush, active-high
//   in_valid   in   1      upstream payload valid
//   in_ready   out  1      stage can accept (decoded from state)
//   in_data    in   WIDTH  upstream payload
//   out_valid  out  1      downstream payload valid (decoded from state)
//   out_ready  in   1      downstream accepts payload
//   out_data   out  WIDTH  payload to downstream (main register)
//   occupancy  out  2      entries held: 0, 1 or 2
//   stall_cnt  out  CNT_W  saturating count of out_valid & !out_ready cycles
// ----------------------------------------------------------------------------
module pl_reg_skid
    import pl_pkg::*;
#(
    parameter int WIDTH    = 131,
    parameter int CNT_W    = 16,
    parameter bit CLR_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] main_d;
    logic             load_main;
    logic             load_skid;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and payload-register load controls.
    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        main_d    = in_data;

        case (state)
            S_EMPTY: begin
                if (in_fire) begin
                    load_main = 1'b1;
                    state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    // Downstream stalled while a new word arrived: park it.
                    load_skid = 1'b1;
                    state_nxt = S_FULL;
                end else if (out_fire) begin
                    state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (out_fire) begin
                    main_d    = skid_q;
                    load_main = 1'b1;
                    state_nxt = S_ONE;
                end
            end
            default: begin
                state_nxt = S_EMPTY;
            end
        endcase

        // Flush overrides every transfer in the same cycle.
        if (clr) begin
            state_nxt = S_EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
        end
    end

    // Payload registers: written only on the transitions above or a
    // data-clearing flush, so they stay quiet while the stage idles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (clr) begin
            if (CLR_DATA) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            if (load_main) begin
                main_q <= main_d;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    // Output decode: state only, no combinational path from the handshake
    // inputs to in_ready/out_valid.
    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        occupancy = 2'd0;
        case (state)
            S_EMPTY: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
                occupancy = 2'd0;
            end
            S_ONE: begin
                out_valid = 1'b1;
                in_ready  = 1'b1;
                occupancy = 2'd1;
            end
            S_FULL: begin
                out_valid = 1'b1;
                in_ready  = 1'b0;
                occupancy = 2'd2;
            end
            default: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
                occupancy = 2'd0;
            end
        endcase
    end

    assign out_data = main_q;

    // Stall monitor; flush deliberately does not touch it.
    pl_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk(clk),
        .rst(rst),
        .inc(out_valid & ~out_ready),
        .cnt(stall_cnt)
    );

endmodule : pl_reg_skid

// File: tb/tb_pl_reg_skid.sv
// ----------------------------------------------------------------------------
// tb_pl_reg_skid
// Testbench for pl_reg_skid (WIDTH=32, CNT_W=3, CLR_DATA=1). A 2-deep FIFO
// reference model (a queue) and a saturating stall count are updated on the
// falling edge from the handshake inputs; the monitor pops expected payloads
// whenever downstream accepts and compares out_data, flags and counter.
// ----------------------------------------------------------------------------
module tb_pl_reg_skid;

    localparam int WIDTH   = 32;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] got_q[$];
    int               stall_model = 0;

    pl_reg_skid #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W),
        .CLR_DATA(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: sampled on the falling edge, midway between
    // input changes (posedge+1) and the next active edge.
    always @(negedge clk) begin
        if (rst) begin
            model_q.delete();
            stall_model = 0;
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
            chk("rst_occupancy", {62'd0, occupancy}, 64'd0);
            chk("rst_out_data", {32'd0, out_data}, 64'd0);
            chk("rst_stall_cnt", {61'd0, stall_cnt}, 64'd0);
        end else begin
            int  n;
            bit  take;
            bit  give;
            n = model_q.size();
            chk("out_valid", {63'd0, out_valid}, {63'd0, (n != 0)});
            chk("in_ready", {63'd0, in_ready}, {63'd0, (n < 2)});
            chk("occupancy", {62'd0, occupancy}, 64'(n));
            chk("stall_cnt", {61'd0, stall_cnt}, 64'(stall_model));
            if (n > 2) begin
                chk("model_depth", 64'(n), 64'd2);
            end
            give = out_ready && (n != 0);
            take = in_valid && (n < 2);
            if (give) begin
                chk("out_data", {32'd0, out_data}, {32'd0, model_q[0]});
            end
            // Counter counts at this coming edge regardless of flush.
            if ((n != 0) && !out_ready && stall_model < CNT_MAX) begin
                stall_model++;
            end
            if (clr) begin
                model_q.delete();
            end else begin
                if (give) begin
                    got_q.push_back(model_q.pop_front());
                end
                if (take) begin
                    model_q.push_back(in_data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        // Power-on reset.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Streaming: 0x1..0x8 back-to-back with downstream ready.
        got_q.delete();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
            tick();
            chk("stream_latency", {32'd0, out_data}, 64'(i));
        end
        idle();
        tick();
        tick();
        chk("stream_count", 64'(got_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            chk("stream_order", {32'd0, got_q[i]}, 64'(i + 1));
        end

        // Backpressure: 0xA, 0xB fill the stage, 0xC waits upstream.
        got_q.delete();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hA;
        tick();
        chk("bp_occ_1", {62'd0, occupancy}, 64'd1);
        in_data = 32'hB;
        tick();
        chk("bp_occ_2", {62'd0, occupancy}, 64'd2);
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        in_data = 32'hC;
        tick();
        tick();
        chk("bp_hold_occ", {62'd0, occupancy}, 64'd2);
        chk("bp_hold_data", {32'd0, out_data}, 64'hA);
        out_ready = 1'b1;
        tick();
        for (int k = 0; k < 5 && !in_ready; k++) tick();
        tick();
        idle();
        tick();
        tick();
        chk("bp_count", 64'(got_q.size()), 64'd3);
        if (got_q.size() == 3) begin
            chk("bp_order0", {32'd0, got_q[0]}, 64'hA);
            chk("bp_order1", {32'd0, got_q[1]}, 64'hB);
            chk("bp_order2", {32'd0, got_q[2]}, 64'hC);
        end

        // Async reset while FULL: outputs drop immediately.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        idle();
        chk("pre_rst_occ", {62'd0, occupancy}, 64'd2);
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("arst_occupancy", {62'd0, occupancy}, 64'd0);
        chk("arst_out_data", {32'd0, out_data}, 64'd0);
        chk("arst_stall_cnt", {61'd0, stall_cnt}, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Flush while FULL with 0xC on the input.
        got_q.delete();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        clr = 1'b1;
        in_data = 32'hC;
        tick();
        idle();
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_out_data", {32'd0, out_data}, 64'd0);
        chk("flush_occ", {62'd0, occupancy}, 64'd0);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("flush_nothing_out", 64'(got_q.size()), 64'd0);

        // Stall counter saturation, immune to flush, cleared by reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("cnt_start", {61'd0, stall_cnt}, 64'd0);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h55;
        tick();
        idle();
        for (int k = 0; k < 10; k++) tick();
        chk("cnt_sat", {61'd0, stall_cnt}, 64'd7);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        chk("cnt_after_clr", {61'd0, stall_cnt}, 64'd7);
        rst = 1'b1;
        #1;
        chk("cnt_after_rst", {61'd0, stall_cnt}, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Random traffic against the reference model.
        for (int k = 0; k < 10000; k++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 99) < 55);
            clr       = ($urandom_range(0, 99) < 2);
            tick();
        end
        idle();
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("final_drained", {62'd0, occupancy}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pl_reg_skid
